// File: rtl/hazard_ctrl_pkg.sv
// Shared core definitions for the pipeline hazard sequencer.
// Provides RV32I opcode constants, register-address width, the sequencer
// state encoding and the packed bundle of pipeline control strobes.
package hazard_ctrl_pkg;

  localparam int unsigned OPCODE_W       = 7;
  localparam int unsigned REG_ADDR_WIDTH = 5;

  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    HZ_RUN        = 2'd0,
    HZ_MEM_WAIT   = 2'd1,
    HZ_REDIR_PEND = 2'd2
  } hz_state_e;

  // Hold/flush strobes towards the stage registers.
  typedef struct packed {
    logic stall_pc;
    logic stall_ifid;
    logic stall_idex;
    logic stall_exmem;
    logic flush_ifid;
    logic flush_idex;
    logic mem_timeout;
  } hz_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline stage registers and the hazard sequencer.
// master: pipeline side (drives EX/ID operand info, redirect, dmem status).
// slave : hazard_ctrl (drives stall/flush strobes, timeout pulse, counters).
interface hazard_ctrl_if #(
  parameter int unsigned CNT_WIDTH = 16
);
  import hazard_ctrl_pkg::*;

  logic [OPCODE_W-1:0]       op_code_idex;
  logic                      gpr_we_idex;
  logic [REG_ADDR_WIDTH-1:0] addr_rd_idex;
  logic [REG_ADDR_WIDTH-1:0] addr_rs1_id;
  logic [REG_ADDR_WIDTH-1:0] addr_rs2_id;
  logic                      rs1_used_id;
  logic                      rs2_used_id;
  logic                      jump_en;
  logic                      dmem_req;
  logic                      dmem_ready;

  logic                      stall_pc;
  logic                      stall_ifid;
  logic                      stall_idex;
  logic                      stall_exmem;
  logic                      flush_ifid;
  logic                      flush_idex;
  logic                      mem_timeout;
  logic [CNT_WIDTH-1:0]      cnt_stall;
  logic [CNT_WIDTH-1:0]      cnt_flush;

  modport master (
    output op_code_idex, gpr_we_idex, addr_rd_idex, addr_rs1_id, addr_rs2_id,
           rs1_used_id, rs2_used_id, jump_en, dmem_req, dmem_ready,
    input  stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid,
           flush_idex, mem_timeout, cnt_stall, cnt_flush
  );

  modport slave (
    input  op_code_idex, gpr_we_idex, addr_rd_idex, addr_rs1_id, addr_rs2_id,
           rs1_used_id, rs2_used_id, jump_en, dmem_req, dmem_ready,
    output stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid,
           flush_idex, mem_timeout, cnt_stall, cnt_flush
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter for performance events.
// Ports: clk, rst_n (async active-low clear), inc (count this cycle),
//        q (count, sticks at all-ones).
module sat_counter #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32I core: load-use bubble insertion,
// EX redirect flushes, whole-pipe freeze on multi-cycle data-memory access
// with a bounded wait, plus stall-cycle and redirect-event counters.
// Ports: clk, rst_n (async active-low), hz (slave side of hazard_ctrl_if).
// Control strobes are Mealy (state + current inputs); counters are registered.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hz
);

  localparam int unsigned TIMER_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_e          state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               pend_q, pend_d;
  hz_ctrl_t           ctrl_c;
  logic               load_use_c;

  // Load in EX whose rd (never x0) feeds a source the ID instruction reads.
  assign load_use_c = (hz.op_code_idex == OP_LOAD) && hz.gpr_we_idex &&
                      (hz.addr_rd_idex != '0) &&
                      ((hz.rs1_used_id && (hz.addr_rs1_id == hz.addr_rd_idex)) ||
                       (hz.rs2_used_id && (hz.addr_rs2_id == hz.addr_rd_idex)));

  // State, wait timer and deferred-redirect flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HZ_RUN;
      timer_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
    end
  end

  // Next state and Mealy strobes; strobes are forced low while reset is held.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pend_d  = pend_q;
    ctrl_c  = '0;
    if (rst_n) begin
      case (state_q)
        HZ_RUN: begin
          if (hz.dmem_req && !hz.dmem_ready) begin
            ctrl_c.stall_pc    = 1'b1;
            ctrl_c.stall_ifid  = 1'b1;
            ctrl_c.stall_idex  = 1'b1;
            ctrl_c.stall_exmem = 1'b1;
            state_d            = HZ_MEM_WAIT;
            timer_d            = TIMER_W'(1);
            // A redirect seen while freezing is replayed on release.
            pend_d             = hz.jump_en;
          end else if (hz.jump_en) begin
            ctrl_c.flush_ifid = 1'b1;
            ctrl_c.flush_idex = 1'b1;
          end else if (load_use_c) begin
            ctrl_c.stall_pc   = 1'b1;
            ctrl_c.stall_ifid = 1'b1;
            ctrl_c.flush_idex = 1'b1;
          end
        end
        HZ_MEM_WAIT: begin
          if (hz.dmem_ready || (timer_q == TIMER_W'(MEM_TIMEOUT))) begin
            ctrl_c.mem_timeout = !hz.dmem_ready;
            ctrl_c.flush_ifid  = pend_q;
            ctrl_c.flush_idex  = pend_q;
            pend_d             = 1'b0;
            timer_d            = '0;
            state_d            = HZ_RUN;
          end else begin
            ctrl_c.stall_pc    = 1'b1;
            ctrl_c.stall_ifid  = 1'b1;
            ctrl_c.stall_idex  = 1'b1;
            ctrl_c.stall_exmem = 1'b1;
            timer_d            = timer_q + TIMER_W'(1);
          end
        end
        default: begin
          state_d = HZ_RUN;
        end
      endcase
    end
  end

  assign hz.stall_pc    = ctrl_c.stall_pc;
  assign hz.stall_ifid  = ctrl_c.stall_ifid;
  assign hz.stall_idex  = ctrl_c.stall_idex;
  assign hz.stall_exmem = ctrl_c.stall_exmem;
  assign hz.flush_ifid  = ctrl_c.flush_ifid;
  assign hz.flush_idex  = ctrl_c.flush_idex;
  assign hz.mem_timeout = ctrl_c.mem_timeout;

  // stall_pc marks every lost cycle; flush_ifid marks every redirect event.
  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctrl_c.stall_pc),
    .q     (hz.cnt_stall)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_flush (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctrl_c.flush_ifid),
    .q     (hz.cnt_flush)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=4, 4-bit counters).
// Expected strobe vectors are queued when a step is driven and popped when the
// DUT is sampled; counter expectations come from a saturating reference count.
module tb_hazard_ctrl;

  localparam int unsigned CW = 4;

  // {stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex, mem_timeout}
  localparam logic [6:0] E_NONE = 7'b0000000;
  localparam logic [6:0] E_LU   = 7'b1100010;
  localparam logic [6:0] E_FL   = 7'b0000110;
  localparam logic [6:0] E_ST   = 7'b1111000;
  localparam logic [6:0] E_TO   = 7'b0000001;
  localparam logic [6:0] E_TOF  = 7'b0000111;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] ADD    = 7'b0110011;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [6:0]    exp_q[$];
  string         tag_q[$];
  logic [CW-1:0] cs_m;
  logic [CW-1:0] cf_m;

  hazard_ctrl_if #(.CNT_WIDTH(CW)) hz ();

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] ctrl_now();
    return {hz.stall_pc, hz.stall_ifid, hz.stall_idex, hz.stall_exmem,
            hz.flush_ifid, hz.flush_idex, hz.mem_timeout};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ex(input logic [6:0] opc, input logic we, input logic [4:0] rd);
    hz.op_code_idex = opc;
    hz.gpr_we_idex  = we;
    hz.addr_rd_idex = rd;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2);
    hz.addr_rs1_id = rs1;
    hz.rs1_used_id = u1;
    hz.addr_rs2_id = rs2;
    hz.rs2_used_id = u2;
  endtask

  task automatic set_mem(input logic jmp, input logic req, input logic rdy);
    hz.jump_en    = jmp;
    hz.dmem_req   = req;
    hz.dmem_ready = rdy;
  endtask

  // One cycle: inputs already driven just after a rising edge.
  task automatic step(input string tag, input logic [6:0] exp);
    logic [6:0] e;
    string      t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    if (exp[6] && (cs_m != '1)) cs_m = cs_m + CW'(1);
    if (exp[2] && (cf_m != '1)) cf_m = cf_m + CW'(1);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, 16'(ctrl_now()), 16'(e));
    @(posedge clk);
    #1;
    check({t, ".cnt_stall"}, 16'(hz.cnt_stall), 16'(cs_m));
    check({t, ".cnt_flush"}, 16'(hz.cnt_flush), 16'(cf_m));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cs_m     = '0;
    cf_m     = '0;

    // Reset held with hazard, redirect and pending memory all asserted.
    rst_n = 1'b0;
    set_ex(LOAD, 1'b1, 5'd5);
    set_id(5'd5, 1'b1, 5'd1, 1'b1);
    set_mem(1'b1, 1'b1, 1'b0);
    #2;
    check("reset.ctrl", 16'(ctrl_now()), 16'(E_NONE));
    check("reset.cnt_stall", 16'(hz.cnt_stall), 16'd0);
    check("reset.cnt_flush", 16'(hz.cnt_flush), 16'd0);
    @(posedge clk);
    #1;
    set_mem(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // lw x5 in EX, add x6,x5,x1 in ID: one bubble, then the bubble clears it.
    step("lu.rs1", E_LU);
    set_ex(7'd0, 1'b0, 5'd0);
    step("lu.bubble", E_NONE);

    // lw x0 never hazards, even when ID reads x0.
    set_ex(LOAD, 1'b1, 5'd0);
    set_id(5'd0, 1'b1, 5'd0, 1'b1);
    step("lu.x0", E_NONE);

    // rs2 matches but is not read.
    set_ex(LOAD, 1'b1, 5'd5);
    set_id(5'd1, 1'b1, 5'd5, 1'b0);
    step("lu.rs2_unused", E_NONE);
    hz.rs2_used_id = 1'b1;
    step("lu.rs2", E_LU);

    // Non-load producer and load without write-enable.
    set_ex(ADD, 1'b1, 5'd5);
    set_id(5'd5, 1'b1, 5'd0, 1'b0);
    step("lu.not_load", E_NONE);
    set_ex(LOAD, 1'b0, 5'd5);
    step("lu.no_we", E_NONE);

    // Redirect beats load-use.
    set_ex(LOAD, 1'b1, 5'd5);
    hz.jump_en = 1'b1;
    step("redirect", E_FL);
    hz.jump_en = 1'b0;
    set_ex(7'd0, 1'b0, 5'd0);

    // Memory wait: three stalled cycles, released on ready.
    set_mem(1'b0, 1'b1, 1'b0);
    step("mw.1", E_ST);
    step("mw.2", E_ST);
    step("mw.3", E_ST);
    hz.dmem_ready = 1'b1;
    step("mw.ready", E_NONE);
    set_mem(1'b0, 1'b0, 1'b0);
    step("mw.run", E_NONE);

    // Deferred redirect: flush only on the release cycle.
    set_mem(1'b1, 1'b1, 1'b0);
    step("dr.1", E_ST);
    step("dr.2", E_ST);
    hz.dmem_ready = 1'b1;
    step("dr.ready", E_FL);
    set_mem(1'b0, 1'b0, 1'b0);
    step("dr.run", E_NONE);

    // Timeout: pulse on wait cycle 4, back in RUN the next cycle.
    set_mem(1'b0, 1'b1, 1'b0);
    step("to.enter", E_ST);
    step("to.w1", E_ST);
    step("to.w2", E_ST);
    step("to.w3", E_ST);
    step("to.w4", E_TO);
    step("to.rerun", E_ST);
    hz.dmem_ready = 1'b1;
    step("to.ready", E_NONE);
    set_mem(1'b0, 1'b0, 1'b0);
    step("to.idle", E_NONE);

    // Timeout with a pending redirect; stall counter saturates at 15.
    set_mem(1'b1, 1'b1, 1'b0);
    step("tp.enter", E_ST);
    step("tp.w1", E_ST);
    step("tp.w2", E_ST);
    step("tp.w3", E_ST);
    step("tp.w4", E_TOF);
    set_mem(1'b0, 1'b0, 1'b0);
    step("tp.idle", E_NONE);
    set_ex(LOAD, 1'b1, 5'd5);
    set_id(5'd5, 1'b1, 5'd0, 1'b0);
    step("sat.lu", E_LU);
    set_ex(7'd0, 1'b0, 5'd0);

    // Reset in the middle of a wait with a redirect pending.
    set_mem(1'b1, 1'b1, 1'b0);
    step("rst.enter", E_ST);
    rst_n = 1'b0;
    #1;
    check("rst.async.ctrl", 16'(ctrl_now()), 16'(E_NONE));
    check("rst.async.cnt_stall", 16'(hz.cnt_stall), 16'd0);
    check("rst.async.cnt_flush", 16'(hz.cnt_flush), 16'd0);
    cs_m = '0;
    cf_m = '0;
    @(posedge clk);
    #1;
    set_mem(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step("rst.run", E_NONE);

    // Pending redirect must not survive reset.
    set_mem(1'b0, 1'b1, 1'b0);
    step("rst.mw", E_ST);
    hz.dmem_ready = 1'b1;
    step("rst.nopend", E_NONE);
    set_mem(1'b0, 1'b0, 1'b0);
    set_ex(LOAD, 1'b1, 5'd7);
    set_id(5'd0, 1'b0, 5'd7, 1'b1);
    step("rst.lu", E_LU);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
